// File: rtl/ccw_sequencer.sv
// ccw_sequencer: runs one channel command word against the channel block,
// metering data beats, capturing ending status and enforcing a timeout.
module ccw_sequencer #(
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             host_addr,
  input  logic [7:0]             host_command,
  input  logic [COUNT_WIDTH-1:0] host_count,
  input  logic                   host_start,
  output logic                   host_busy,
  output logic                   host_done,
  output logic [7:0]             host_status,
  output logic                   host_status_valid,
  output logic [COUNT_WIDTH-1:0] host_residual,
  output logic [1:0]             host_condition_code,
  output logic                   host_timeout,
  input  logic [7:0]             host_send_tdata,
  input  logic                   host_send_tvalid,
  output logic                   host_send_tready,
  output logic [7:0]             host_recv_tdata,
  output logic                   host_recv_tvalid,
  input  logic                   host_recv_tready,
  output logic [7:0]             ch_addr,
  output logic [7:0]             ch_command,
  output logic                   ch_start,
  output logic                   ch_stop,
  input  logic [1:0]             ch_condition_code,
  input  logic [7:0]             ch_status_tdata,
  input  logic                   ch_status_tvalid,
  output logic [7:0]             ch_data_send_tdata,
  output logic                   ch_data_send_tvalid,
  input  logic                   ch_data_send_tready,
  input  logic [7:0]             ch_data_recv_tdata,
  input  logic                   ch_data_recv_tvalid,
  output logic                   ch_data_recv_tready
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] tmo_cnt;

  logic is_wr, is_rd, is_run, ok;
  logic wr_hs, rd_hs, data_hs, busy_beat;
  logic req, stop_cond, end_stat, tmo_hit;

  assign is_wr  = ch_command[1:0] == 2'b01;
  assign is_rd  = ch_command[1:0] == 2'b10;
  assign is_run = state == RUN;
  assign ok     = host_residual != '0;

  assign ch_data_send_tdata  = host_send_tdata;
  assign ch_data_send_tvalid = is_run & is_wr & ok & host_send_tvalid;
  assign host_send_tready    = is_run & is_wr & ok & ch_data_send_tready;

  assign host_recv_tdata     = ch_data_recv_tdata;
  assign host_recv_tvalid    = is_run & is_rd & ok & ch_data_recv_tvalid;
  assign ch_data_recv_tready = is_run & is_rd & ok & host_recv_tready;

  assign wr_hs     = ch_data_send_tvalid & ch_data_send_tready;
  assign rd_hs     = host_recv_tvalid & host_recv_tready;
  assign data_hs   = wr_hs | rd_hs;
  assign busy_beat = data_hs | ch_status_tvalid;

  // Channel still asking for data after the count is spent, or on a NOP.
  assign req       = ch_data_send_tready | ch_data_recv_tvalid;
  assign stop_cond = req & (~(is_wr | is_rd) | ~ok);

  assign end_stat = ch_status_tvalid &
                    (ch_status_tdata[3] | ch_status_tdata[4] |
                     ch_status_tdata[1]);
  assign tmo_hit  = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      tmo_cnt             <= '0;
      ch_start            <= 1'b0;
      ch_stop             <= 1'b0;
      ch_addr             <= '0;
      ch_command          <= '0;
      host_done           <= 1'b0;
      host_busy           <= 1'b0;
      host_status         <= '0;
      host_status_valid   <= 1'b0;
      host_residual       <= '0;
      host_condition_code <= '0;
      host_timeout        <= 1'b0;
    end else begin
      ch_start  <= 1'b0;
      ch_stop   <= 1'b0;
      host_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (host_start) begin
            ch_addr           <= host_addr;
            ch_command        <= host_command;
            host_residual     <= host_count;
            host_status_valid <= 1'b0;
            host_timeout      <= 1'b0;
            host_busy         <= 1'b1;
            state             <= START;
          end
        end
        START: begin
          ch_start <= 1'b1;
          tmo_cnt  <= '0;
          state    <= RUN;
        end
        RUN: begin
          if (data_hs)
            host_residual <= host_residual - COUNT_WIDTH'(1);
          if (ch_status_tvalid) begin
            host_status       <= ch_status_tdata;
            host_status_valid <= 1'b1;
          end
          if (busy_beat) tmo_cnt <= '0;
          else           tmo_cnt <= tmo_cnt + TW'(1);
          if (end_stat) begin
            state <= DONE;
          end else if (!busy_beat && tmo_hit) begin
            host_timeout <= 1'b1;
            state        <= DONE;
          end else begin
            ch_stop <= stop_cond;
          end
        end
        DONE: begin
          host_done           <= 1'b1;
          host_condition_code <= ch_condition_code;
          host_busy           <= 1'b0;
          state               <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccw_sequencer.sv
// tb_ccw_sequencer: drives ccw_sequencer against a behavioural channel mock
// and checks each operation against transaction-level expectations.
module tb_ccw_sequencer;

  localparam int CW = 16;
  localparam int TO = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    host_addr, host_command;
  logic [CW-1:0] host_count;
  logic          host_start, host_busy, host_done;
  logic [7:0]    host_status;
  logic          host_status_valid;
  logic [CW-1:0] host_residual;
  logic [1:0]    host_condition_code;
  logic          host_timeout;
  logic [7:0]    host_send_tdata;
  logic          host_send_tvalid, host_send_tready;
  logic [7:0]    host_recv_tdata;
  logic          host_recv_tvalid, host_recv_tready;
  logic [7:0]    ch_addr, ch_command;
  logic          ch_start, ch_stop;
  logic [1:0]    ch_condition_code;
  logic [7:0]    ch_status_tdata;
  logic          ch_status_tvalid;
  logic [7:0]    ch_data_send_tdata;
  logic          ch_data_send_tvalid, ch_data_send_tready;
  logic [7:0]    ch_data_recv_tdata;
  logic          ch_data_recv_tvalid, ch_data_recv_tready;

  int errors = 0;
  int checks = 0;
  logic [7:0] last_status;

  ccw_sequencer #(.COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .host_addr(host_addr), .host_command(host_command),
    .host_count(host_count), .host_start(host_start),
    .host_busy(host_busy), .host_done(host_done),
    .host_status(host_status), .host_status_valid(host_status_valid),
    .host_residual(host_residual),
    .host_condition_code(host_condition_code),
    .host_timeout(host_timeout),
    .host_send_tdata(host_send_tdata),
    .host_send_tvalid(host_send_tvalid),
    .host_send_tready(host_send_tready),
    .host_recv_tdata(host_recv_tdata),
    .host_recv_tvalid(host_recv_tvalid),
    .host_recv_tready(host_recv_tready),
    .ch_addr(ch_addr), .ch_command(ch_command),
    .ch_start(ch_start), .ch_stop(ch_stop),
    .ch_condition_code(ch_condition_code),
    .ch_status_tdata(ch_status_tdata),
    .ch_status_tvalid(ch_status_tvalid),
    .ch_data_send_tdata(ch_data_send_tdata),
    .ch_data_send_tvalid(ch_data_send_tvalid),
    .ch_data_send_tready(ch_data_send_tready),
    .ch_data_recv_tdata(ch_data_recv_tdata),
    .ch_data_recv_tvalid(ch_data_recv_tvalid),
    .ch_data_recv_tready(ch_data_recv_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] outs();
    return {ch_start, ch_stop, host_done, host_busy, host_status,
            host_status_valid, host_residual, host_condition_code,
            host_timeout, ch_addr, ch_command};
  endfunction

  task automatic idle_inputs();
    host_addr = '0; host_command = '0; host_count = '0;
    host_start = 0; host_send_tdata = '0; host_send_tvalid = 0;
    host_recv_tready = 0; ch_condition_code = '0;
    ch_status_tdata = '0; ch_status_tvalid = 0;
    ch_data_send_tready = 0; ch_data_recv_tdata = '0;
    ch_data_recv_tvalid = 0;
  endtask

  // mode 0: channel moves up to limit bytes then ends (0x0c)
  // mode 1: control unit busy (0x10), mode 2: no response at all
  task automatic run_op(input logic [7:0] addr, input logic [7:0] cmd,
                        input int count, input int limit, input int mode,
                        input logic [1:0] cc, input int poke_at,
                        input int rst_at);
    logic [7:0] dat[$];
    logic [7:0] got[$];
    int dir, n, hi, chn, cyc, ccyc, starts, acyc;
    bit active, sent, junk, stopped, done, leak, busy1, same, exp_stop;
    dir = cmd[1:0] == 2'b01 ? 1 : cmd[1:0] == 2'b10 ? 2 : 0;
    n = (mode != 0 || dir == 0) ? 0 : (count < limit ? count : limit);
    exp_stop = mode == 0 && (dir == 0 || count < limit);
    hi = 0; chn = 0; ccyc = -1; starts = 0; acyc = 0;
    active = 0; sent = 0; junk = 0; stopped = 0; done = 0;
    leak = 0; busy1 = 0;
    for (int i = 0; i < count + limit + 2; i++)
      dat.push_back(8'($urandom));
    host_addr = addr; host_command = cmd;
    host_count = CW'(count); host_start = 1;
    @(posedge clk); #1;
    host_start = 0; host_addr = 8'($urandom);
    host_command = 8'($urandom); host_count = CW'($urandom);
    cyc = 1;
    while (!done && cyc < 300) begin
      ch_status_tvalid = 0; ch_status_tdata = 8'($urandom);
      ch_data_recv_tvalid = 0; ch_data_send_tready = 0;
      ch_data_recv_tdata = dat[chn];
      host_send_tdata = dat[hi];
      host_send_tvalid = 1'($urandom);
      host_recv_tready = 1'($urandom);
      ch_condition_code = cc;
      host_start = cyc == poke_at;
      if (active) begin
        acyc++;
        if (sent && !junk) begin
          ch_status_tvalid = 1; ch_status_tdata = 8'hff; junk = 1;
        end else if (!sent && mode == 1 && acyc == 2) begin
          ch_status_tvalid = 1; ch_status_tdata = 8'h10;
          sent = 1; last_status = 8'h10;
        end else if (!sent && mode == 0) begin
          if (stopped || (dir != 0 && chn >= limit)) begin
            ch_status_tvalid = 1; ch_status_tdata = 8'h0c;
            sent = 1; last_status = 8'h0c;
          end else begin
            if (acyc == 1) begin
              ch_status_tvalid = 1; ch_status_tdata = 8'h20;
              last_status = 8'h20;
            end
            if (dir == 0) ch_data_recv_tvalid = 1;
            else if (dir == 2) ch_data_recv_tvalid = 1'($urandom);
            else ch_data_send_tready = 1'($urandom);
          end
        end
      end
      @(negedge clk);
      if (ch_start) begin
        starts++;
        if (ccyc < 0) ccyc = cyc;
        active = 1;
      end
      if (cyc == 1) busy1 = host_busy;
      if (ch_stop) stopped = 1;
      if (host_done) done = 1;
      if (dir != 1 && (ch_data_send_tvalid || host_send_tready)) leak = 1;
      if (dir != 2 && (host_recv_tvalid || ch_data_recv_tready)) leak = 1;
      if (dir == 2 && host_recv_tvalid && host_recv_tready)
        got.push_back(host_recv_tdata);
      if (dir == 2 && ch_data_recv_tvalid && ch_data_recv_tready) chn++;
      if (dir == 1 && ch_data_send_tvalid && ch_data_send_tready) begin
        got.push_back(ch_data_send_tdata);
        chn++;
      end
      if (dir == 1 && host_send_tvalid && host_send_tready) hi++;
      if (cyc == rst_at) begin
        #2 reset = 1;
        #1 chk("rst_outs", outs(), 0);
        @(posedge clk); #1;
        reset = 0;
        idle_inputs();
        done = 0;
        repeat (20) begin
          @(negedge clk);
          if (host_done) done = 1;
        end
        chk("rst_no_done", done, 0);
        last_status = 8'h00;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    host_start = 0;
    same = 1;
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== dat[i]) same = 0;
    chk("done_seen", done, 1);
    chk("done_pulse", host_done, 0);
    chk("idle_after", host_busy, 0);
    chk("busy_early", busy1, 1);
    chk("start_lat", ccyc, 2);
    chk("start_cnt", starts, 1);
    chk("residual", host_residual, count - n);
    chk("nbytes", got.size(), n);
    chk("data", same, 1);
    chk("xfer_other", dir == 1 ? hi : chn, n);
    chk("stop", stopped, exp_stop);
    chk("status", host_status, last_status);
    chk("status_valid", host_status_valid, mode != 2);
    chk("timeout", host_timeout, mode == 2);
    chk("cc", host_condition_code, cc);
    chk("gating", leak, 0);
    chk("addr", ch_addr, addr);
    chk("cmd", ch_command, cmd);
  endtask

  initial begin
    logic [7:0] cmd;
    idle_inputs();
    last_status = 8'h00;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 chk("reset_outs", outs(), 0);
    reset = 0;
    @(posedge clk); #1;
    chk("idle_outs", outs(), 0);
    run_op(8'h10, 8'h02, 6, 16, 2, 2'd3, 0, 0);
    run_op(8'h1a, 8'h02, 6, 16, 1, 2'd1, 0, 0);
    run_op(8'h1a, 8'h02, 6, 16, 1, 2'd2, 3, 0);
    run_op(8'h1a, 8'h02, 6, 16, 0, 2'd0, 4, 0);
    run_op(8'h1a, 8'h02, 16, 6, 0, 2'd0, 0, 0);
    run_op(8'h1a, 8'h01, 6, 16, 0, 2'd0, 0, 0);
    run_op(8'h1a, 8'h01, 16, 6, 0, 2'd1, 2, 0);
    run_op(8'h1a, 8'h03, 0, 16, 0, 2'd0, 0, 0);
    run_op(8'h1a, 8'h02, 40, 40, 0, 2'd0, 0, 9);
    run_op(8'h1a, 8'h02, 5, 5, 0, 2'd0, 0, 0);
    repeat (20) begin
      cmd = 8'($urandom);
      run_op(8'($urandom), cmd, $urandom_range(0, 10),
             $urandom_range(1, 10), ($urandom % 5 == 0) ? 1 : 0,
             2'($urandom), $urandom_range(0, 4), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccw_sequencer.md
Name: ccw_sequencer

Overview:
- Sits directly upstream of `channel`. It accepts one channel command (address, command byte, byte count) from the host side and drives `channel`'s start/addr/command inputs.
- It meters data between host byte streams and `channel`'s data_send/data_recv streams, and stops the transfer when the count reaches zero.
- It captures ending status, reports residual count, condition code and completion to the host. It also enforces a no-activity timeout.

Parameters:
- COUNT_WIDTH, 16, width of byte count and residual.
- TIMEOUT_CYCLES, 256, idle cycles in RUN (no status/data beat) before forced completion; must be >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- host_addr  in  8  device address, sampled on accepted host_start
- host_command  in  8  command byte, sampled on accepted host_start
- host_count  in  COUNT_WIDTH  byte count, sampled on accepted host_start
- host_start  in  1  request; accepted only in IDLE
- host_busy  out  1  high in any state other than IDLE
- host_done  out  1  one-cycle completion pulse
- host_status  out  8  last ending-status byte of current/last operation
- host_status_valid  out  1  a status byte was captured in the last operation
- host_residual  out  COUNT_WIDTH  remaining count
- host_condition_code  out  2  ch_condition_code sampled at completion
- host_timeout  out  1  last operation ended by timeout
- host_send_tdata/tvalid/tready  in/in/out  8/1/1  write-data stream from host
- host_recv_tdata/tvalid/tready  out/out/in  8/1/1  read-data stream to host
- ch_addr, ch_command  out  8 each  to channel addr/command
- ch_start, ch_stop  out  1 each  to channel start/stop
- ch_condition_code  in  2  from channel
- ch_status_tdata/tvalid  in  8/1  from channel
- ch_data_send_tdata/tvalid/tready  out/out/in  8/1/1  to channel
- ch_data_recv_tdata/tvalid/tready  in/in/out  8/1/1  from channel

Behaviour:
- Reset, asynchronous:
  - state = IDLE.
  - All outputs 0: ch_start, ch_stop, host_done, host_busy, host_status, host_status_valid, host_residual, host_condition_code, host_timeout, ch_addr, ch_command.
  - Timeout counter cleared.
  - Reset mid-operation aborts without a host_done pulse.
- Direction decode, on the latched command:
  - WRITE when cmd[1:0]=01.
  - READ when cmd[1:0]=10.
  - Otherwise NODATA.
- IDLE:
  - host_start=1 latches addr/command into ch_addr/ch_command and count into host_residual.
  - Clears host_status_valid and host_timeout, then goes to START.
  - host_start in any other state is ignored.
- START: ch_start=1 for exactly one cycle, then RUN.
- RUN, combinational gating with ok = (host_residual != 0):
  - WRITE: ch_data_send_tvalid = host_send_tvalid & ok; host_send_tready = ch_data_send_tready & ok; tdata passes straight through.
  - READ: host_recv_tvalid = ch_data_recv_tvalid & ok; ch_data_recv_tready = host_recv_tready & ok; tdata passes straight through.
  - NODATA, and the unused stream in READ/WRITE: tvalid/tready held 0.
  - Each completed handshake decrements host_residual by 1. It never wraps below 0.
- Stop generation (registered):
  - In RUN, ch_stop is asserted the cycle after a cycle with a channel data request (ch_data_send_tready or ch_data_recv_tvalid) and residual=0, or any data request during NODATA.
  - It stays asserted while that condition persists.
  - ch_stop is 0 outside RUN.
- Status capture in RUN:
  - ch_status_tvalid loads host_status and sets host_status_valid.
  - If the byte has bit3 (channel end), bit4 (busy) or bit1 (unit check) set, go to DONE next cycle.
  - Otherwise stay in RUN.
  - Status beats outside RUN are ignored.
- Timeout:
  - The counter clears on entry to RUN and on any status or data handshake, and increments otherwise.
  - Reaching TIMEOUT_CYCLES-1 sets host_timeout and goes to DONE.
- DONE:
  - host_done=1 for one cycle and host_condition_code = ch_condition_code, then IDLE.
  - Outputs hold until the next accepted start.
- Simultaneous status and data handshake in the same cycle: both take effect (decrement and capture).
- Latency: host_start to ch_start = 2 cycles. Data path adds zero cycles.

Test Plan (with `channel` + mock_cu ADDRESS 8'h1a):
- No CU: start addr 8'h10, READ 8'h02, count 6 -> within 300 cycles host_done; host_timeout=1; host_condition_code=3; host_residual=6; host_status_valid=0.
- mock_busy=1: start 8'h1a, READ, count 6 -> host_done; host_status=8'h10; host_residual=6; host_timeout=0. Repeat with mock_short_busy=1 for the same result.
- READ, count 6, mock_limit 16, host_recv_tready=1 -> exactly 6 bytes on host_recv; ch_stop asserted; host_residual=0; state IDLE after done.
- READ, count 16, mock_limit 6 -> 6 bytes received; host_residual=10; channel-end status captured; ch_stop never asserted.
- WRITE 8'h01: (a) count 6, limit 16, host_send bytes 1..6 -> residual 0, ch_stop asserted; (b) count 16, limit 6 -> residual 10, 7th byte never accepted.
- host_start pulsed while busy -> ignored, no second ch_start. Reset asserted mid-READ -> all outputs 0 immediately, no host_done. NOP 8'h03, count 0 -> done, ch_data tvalid/tready never 1.
